// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR: per-channel tap delay lines, one shared coefficient
// bank and a single time-multiplexed pre-add/multiply/accumulate datapath.

module fir_sym_mc_dline #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 22
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             shift_i,
  input  logic [DATA_W-1:0]                din_i,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]  taps_o
);
  logic [NUM_TAPS-1:0][DATA_W-1:0] x_q, x_d;

  always_comb begin
    x_d = x_q;
    if (clr_i)        x_d = '0;
    else if (shift_i) x_d = {x_q[NUM_TAPS-2:0], din_i};
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) x_q <= '0;
    else       x_q <= x_d;

  assign taps_o = x_q;
endmodule

module fir_sym_mc #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int NUM_TAPS = 22,
  parameter int NUM_CH   = 2,
  parameter int OUT_W    = 20,
  localparam int H       = NUM_TAPS / 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW      = (H > 1) ? $clog2(H) : 1
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(H) + 1;
  localparam int SUM_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int TW     = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;
  state_e state_q, state_d;

  logic start, mac_en, out_en, flush_en, coef_en;
  logic ch_ok, addr_ok, k_last;

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [AW-1:0]     k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [H-1:0][COEF_W-1:0] coef_q;

  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_sat_q;

  assign ch_ok   = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(H));
  assign k_last  = (k_q == AW'(H-1));

  // FSM: state register / next state / outputs
  always_ff @(posedge CLK_Filter or posedge rst)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)  state_d = S_MAC;
      S_MAC:   if (k_last) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    mac_en   = 1'b0;
    out_en   = 1'b0;
    flush_en = 1'b0;
    coef_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = !flush;
        // out-of-range channels still handshake but never start a calculation
        start    = in_valid && !flush && ch_ok;
        flush_en = flush;
        coef_en  = coef_we && addr_ok;
      end
      S_MAC:   mac_en = 1'b1;
      S_OUT:   out_en = 1'b1;
      default: ;
    endcase
  end

  // Per-channel delay lines
  logic [NUM_CH-1:0][NUM_TAPS-1:0][DATA_W-1:0] taps;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fir_sym_mc_dline #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) u_dline (
      .clk_i   (CLK_Filter),
      .rst_i   (rst),
      .clr_i   (flush_en),
      .shift_i (start && (in_ch == CH_W'(c))),
      .din_i   (in_data),
      .taps_o  (taps[c])
    );
  end

  always_ff @(posedge CLK_Filter or posedge rst)
    if (rst)          coef_q <= '0;
    else if (coef_en) coef_q[coef_addr] <= coef_data;

  // Shared datapath: x[k] and its mirror x[N-1-k] share coef[k]
  logic [NUM_TAPS-1:0][DATA_W-1:0] xs;
  logic [TW-1:0]     ki, kmi;
  logic [PRE_W-1:0]  pre;
  logic [PROD_W-1:0] prod;

  assign xs   = taps[ch_q];
  assign ki   = TW'(k_q);
  assign kmi  = TW'(NUM_TAPS-1) - ki;
  assign pre  = PRE_W'(xs[ki]) + PRE_W'(xs[kmi]);
  assign prod = PROD_W'(pre) * PROD_W'(coef_q[k_q]);

  always_comb begin
    ch_d  = ch_q;
    k_d   = k_q;
    acc_d = acc_q;
    if (start) begin
      ch_d  = in_ch;
      k_d   = '0;
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + ACC_W'(prod);
      k_d   = k_q + AW'(1);
    end
  end

  always_ff @(posedge CLK_Filter or posedge rst)
    if (rst) begin
      ch_q  <= '0;
      k_q   <= '0;
      acc_q <= '0;
    end else begin
      ch_q  <= ch_d;
      k_q   <= k_d;
      acc_q <= acc_d;
    end

  // Saturating output register; values hold until the next result
  logic [SUM_W-1:0] acc_ext;
  logic             sat;

  assign acc_ext = SUM_W'(acc_q);
  assign sat     = acc_ext > SUM_W'({OUT_W{1'b1}});

  always_ff @(posedge CLK_Filter or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_en;
      if (out_en) begin
        out_ch_q   <= ch_q;
        out_data_q <= sat ? {OUT_W{1'b1}} : acc_ext[OUT_W-1:0];
        out_sat_q  <= sat;
      end
    end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_fir_sym_mc.sv
// Bench for fir_sym_mc: two instances (OUT_W 20 and 16) share stimulus and are
// compared every cycle against a direct-form FIR model of the filter.

module tb_fir_sym_mc;
  localparam int NCH  = 3;
  localparam int TAPS = 22;
  localparam int H    = 11;

  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, flush = 1'b0, coef_we = 1'b0;
  logic [1:0] in_ch = '0;
  logic [7:0] in_data = '0, coef_data = '0;
  logic [3:0] coef_addr = '0;

  logic        in_ready, ov, os, in_ready16, ov16, os16;
  logic [1:0]  och, och16;
  logic [19:0] od;
  logic [15:0] od16;

  always #5 clk = ~clk;

  fir_sym_mc #(.NUM_CH(NCH), .OUT_W(20)) dut (
    .CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov),
    .out_ch(och), .out_data(od), .out_sat(os));

  fir_sym_mc #(.NUM_CH(NCH), .OUT_W(16)) dut16 (
    .CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_ch(in_ch), .in_data(in_data), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov16),
    .out_ch(och16), .out_data(od16), .out_sat(os16));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int ch; longint y; } exp_t;
  exp_t   q[$];
  int     coef_m[H];
  int     hist[NCH][TAPS];
  int     nc = 0, busy_until = 0, last_ch = 0;
  longint last_y = 0;
  longint dut_by_ch[NCH];

  function automatic longint fir(input int ch);
    longint s = 0;
    for (int i = 0; i < TAPS; i++)
      s += longint'(coef_m[(i < H) ? i : TAPS-1-i]) * hist[ch][i];
    return s;
  endfunction

  function automatic longint clip(input longint y, input int w);
    longint m = (longint'(1) << w) - 1;
    return (y > m) ? m : y;
  endfunction

  always @(negedge clk) begin
    bit idle;
    nc++;
    if (rst) begin
      q.delete();
      busy_until = 0; last_y = 0; last_ch = 0;
      foreach (coef_m[k]) coef_m[k] = 0;
      foreach (hist[c, i]) hist[c][i] = 0;
      chk("rst_ov", ov, 0);   chk("rst_od", od, 0);   chk("rst_os", os, 0);
      chk("rst_och", och, 0); chk("rst_ready", in_ready, 1); chk("rst_od16", od16, 0);
    end else begin
      idle = (nc >= busy_until);
      chk("in_ready", in_ready, idle && !flush);
      chk("in_ready16", in_ready16, idle && !flush);
      if (q.size() > 0 && q[0].due == nc) begin
        chk("out_valid", ov, 1);
        chk("out_valid16", ov16, 1);
        last_y = q[0].y; last_ch = q[0].ch;
        dut_by_ch[och] = od;
        void'(q.pop_front());
      end else begin
        chk("out_valid_low", ov, 0);
        chk("out_valid16_low", ov16, 0);
      end
      chk("out_data", od, clip(last_y, 20));
      chk("out_sat", os, last_y > clip(last_y, 20));
      chk("out_ch", och, last_ch);
      chk("out_data16", od16, clip(last_y, 16));
      chk("out_sat16", os16, last_y > clip(last_y, 16));
      if (idle) begin
        if (coef_we && coef_addr < H) coef_m[coef_addr] = coef_data;
        if (flush) foreach (hist[c, i]) hist[c][i] = 0;
        else if (in_valid && in_ch < NCH) begin
          for (int i = TAPS-1; i > 0; i--) hist[in_ch][i] = hist[in_ch][i-1];
          hist[in_ch][0] = in_data;
          q.push_back('{nc + 13, int'(in_ch), fir(int'(in_ch))});
          busy_until = nc + 13;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'(d);
    wait_cyc(1);
    coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input int d, input bit we = 0, input int a = 0, input int cd = 0);
    int n = 0;
    in_valid = 1'b1; in_ch = 2'(ch); in_data = 8'(d);
    coef_we = we; coef_addr = 4'(a); coef_data = 8'(cd);
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("send_timeout", 0, 1);
    wait_cyc(1);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic prog();
    int c[H] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
    for (int k = 0; k < H; k++) wr_coef(k, c[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    // T1 impulse
    prog();
    send(0, 1);
    repeat (21) send(0, 0);
    wait_cyc(15);
    // T2 DC on ch1
    repeat (22) send(1, 255);
    wait_cyc(15);
    chk("t2_dc", od, 353430);
    chk("t2_dc16", od16, 65535);
    chk("t2_sat16", os16, 1);
    chk("t2_sat", os, 0);
    // T3 interleave
    for (int i = 0; i < 22; i++) begin send(0, 10); send(1, 200); end
    wait_cyc(15);
    chk("t3_ch0", dut_by_ch[0], 13860);
    chk("t3_ch1", dut_by_ch[1], 277200);
    // T4 continuous back-pressure, plus out-of-range channel drop
    for (int i = 0; i < 10; i++) send(2, $urandom_range(0, 255));
    send(3, 77);
    send(2, 5);
    wait_cyc(15);
    // T5 reset mid-MAC
    send(0, 1);
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    send(0, 1);
    wait_cyc(15);
    chk("t5_zero", od, 0);
    // T6 busy writes/flush ignored, then IDLE flush
    prog();
    send(0, 1);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd99; flush = 1'b1;
    wait_cyc(1);
    coef_we = 1'b0; flush = 1'b0;
    repeat (21) send(0, 0);
    send(0, 50);
    wait_cyc(15);
    flush = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd9;
    wait_cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    send(0, 1);
    wait_cyc(14);
    chk("t6_flush", od, 2);
    // randomized mix, including same-cycle coefficient write + sample
    for (int it = 0; it < 300; it++) begin
      int r = $urandom_range(0, 9);
      if (r <= 4)      send($urandom_range(0, 3), $urandom_range(0, 255));
      else if (r == 5) send($urandom_range(0, 2), $urandom_range(0, 255), 1,
                            $urandom_range(0, 15), $urandom_range(0, 255));
      else if (r <= 7) wr_coef($urandom_range(0, 15), $urandom_range(0, 255));
      else if (r == 8) begin flush = 1'b1; wait_cyc(1); flush = 1'b0; end
      else             wait_cyc($urandom_range(1, 5));
    end
    wait_cyc(20);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
